// File: rtl/control_unit_if.sv
// Control bundle between the control FSM and the matrix-multiplier datapath.
// master = control unit (decodes ir/z, drives strobes); slave = datapath.
interface control_unit_if;
  logic [7:0]  ir;
  logic        z;
  logic        end_op;
  logic [1:0]  inc;
  logic [3:0]  alu_mode;
  logic [3:0]  bus_ld;
  logic [13:0] write_en;
  logic [3:0]  clr;
  logic        dm_wr;
  logic        im_wr;

  modport master (
    input  ir, z,
    output end_op, inc, alu_mode, bus_ld, write_en, clr, dm_wr, im_wr
  );

  modport slave (
    output ir, z,
    input  end_op, inc, alu_mode, bus_ld, write_en, clr, dm_wr, im_wr
  );
endinterface

// File: rtl/control_unit.sv
// Control FSM: 3-cycle fetch, 1-3 cycle execute per opcode, HALT on ENDOP.
// Outputs are decoded from state plus live ir/z; no backpressure, reset forces all outputs to 0.
module control_unit (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master cu
);

  localparam logic [7:0] OP_LDAC   = 8'd1;
  localparam logic [7:0] OP_LDARR1 = 8'd2;
  localparam logic [7:0] OP_ADDTR  = 8'd10;
  localparam logic [7:0] OP_STACI  = 8'd13;
  localparam logic [7:0] OP_MULT   = 8'd15;
  localparam logic [7:0] OP_JPNZ   = 8'd27;
  localparam logic [7:0] OP_ENDOP  = 8'd28;

  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd3;

  localparam logic [3:0] BUS_PC = 4'd1;
  localparam logic [3:0] BUS_AC = 4'd3;
  localparam logic [3:0] BUS_R  = 4'd4;
  localparam logic [3:0] BUS_R1 = 4'd5;
  localparam logic [3:0] BUS_DM = 4'd8;
  localparam logic [3:0] BUS_IM = 4'd9;

  localparam int WE_AR = 0;
  localparam int WE_PC = 1;
  localparam int WE_IR = 2;
  localparam int WE_DR = 3;
  localparam int WE_AC = 4;

  localparam int INC_PC = 0;
  localparam int INC_AR = 1;

  typedef enum logic [2:0] {
    FETCH1,
    FETCH2,
    FETCH3,
    EX1,
    EX2,
    EX3,
    HALT
  } state_t;

  state_t state;
  // Low for the first edge after reset release so FETCH1 lasts a full cycle.
  logic   run;

  logic        end_op_d;
  logic [1:0]  inc_d;
  logic [3:0]  alu_mode_d;
  logic [3:0]  bus_ld_d;
  logic [13:0] write_en_d;
  logic        dm_wr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH1;
      run   <= 1'b0;
    end else if (!run) begin
      run   <= 1'b1;
    end else begin
      case (state)
        FETCH1: state <= FETCH2;
        FETCH2: state <= FETCH3;
        FETCH3: state <= EX1;
        EX1: begin
          case (cu.ir)
            OP_LDAC,
            OP_ADDTR,
            OP_STACI: state <= EX2;
            // z is only consulted here; EX2 of JPNZ is committed regardless of later z.
            OP_JPNZ:  state <= cu.z ? FETCH1 : EX2;
            OP_ENDOP: state <= HALT;
            default:  state <= FETCH1;
          endcase
        end
        EX2:     state <= (cu.ir == OP_STACI) ? EX3 : FETCH1;
        EX3:     state <= FETCH1;
        HALT:    state <= HALT;
        default: state <= FETCH1;
      endcase
    end
  end

  always_comb begin
    end_op_d   = 1'b0;
    inc_d      = '0;
    alu_mode_d = '0;
    bus_ld_d   = '0;
    write_en_d = '0;
    dm_wr_d    = 1'b0;
    if (!rst && run) begin
      case (state)
        FETCH1: begin
          bus_ld_d          = BUS_PC;
          write_en_d[WE_AR] = 1'b1;
        end
        FETCH2: inc_d[INC_PC] = 1'b1;
        FETCH3: begin
          bus_ld_d          = BUS_IM;
          write_en_d[WE_IR] = 1'b1;
        end
        EX1: begin
          case (cu.ir)
            OP_LDAC:   bus_ld_d = BUS_DM;
            OP_LDARR1: begin
              bus_ld_d          = BUS_R1;
              write_en_d[WE_AR] = 1'b1;
            end
            OP_ADDTR:  bus_ld_d = BUS_R;
            OP_STACI: begin
              bus_ld_d          = BUS_AC;
              write_en_d[WE_DR] = 1'b1;
            end
            OP_MULT: begin
              bus_ld_d          = BUS_R;
              alu_mode_d        = ALU_MUL;
              write_en_d[WE_AC] = 1'b1;
            end
            OP_JPNZ: begin
              if (cu.z) begin
                inc_d[INC_PC] = 1'b1;
              end else begin
                bus_ld_d          = BUS_PC;
                write_en_d[WE_AR] = 1'b1;
              end
            end
            OP_ENDOP:  end_op_d = 1'b1;
            default: ;
          endcase
        end
        EX2: begin
          case (cu.ir)
            OP_LDAC: begin
              bus_ld_d          = BUS_DM;
              write_en_d[WE_AC] = 1'b1;
            end
            OP_ADDTR: begin
              bus_ld_d          = BUS_R;
              alu_mode_d        = ALU_ADD;
              write_en_d[WE_AC] = 1'b1;
            end
            OP_STACI: dm_wr_d = 1'b1;
            OP_JPNZ: begin
              bus_ld_d          = BUS_IM;
              write_en_d[WE_PC] = 1'b1;
            end
            default: ;
          endcase
        end
        EX3: begin
          if (cu.ir == OP_STACI) begin
            inc_d[INC_AR] = 1'b1;
          end
        end
        HALT:    end_op_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign cu.end_op   = end_op_d;
  assign cu.inc      = inc_d;
  assign cu.alu_mode = alu_mode_d;
  assign cu.bus_ld   = bus_ld_d;
  assign cu.write_en = write_en_d;
  assign cu.dm_wr    = dm_wr_d;
  assign cu.clr      = '0;
  assign cu.im_wr    = 1'b0;

  a_we_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(cu.write_en));
  a_alu_legal:  assert property (@(posedge clk) disable iff (rst) cu.alu_mode <= 4'd5);
  a_bus_legal:  assert property (@(posedge clk) disable iff (rst) cu.bus_ld <= 4'd9);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: reset/abort sequences, a fixed opcode table and randomized
// instruction streams compared cycle by cycle against an opcode-level reference model.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_unit_if cu ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .cu  (cu)
  );

  typedef struct packed {
    logic        end_op;
    logic [1:0]  inc;
    logic [3:0]  alu_mode;
    logic [3:0]  bus_ld;
    logic [13:0] write_en;
    logic [3:0]  clr;
    logic        dm_wr;
    logic        im_wr;
  } out_t;

  out_t act;
  assign act = {cu.end_op, cu.inc, cu.alu_mode, cu.bus_ld, cu.write_en, cu.clr, cu.dm_wr, cu.im_wr};

  int checks   = 0;
  int failures = 0;

  function automatic out_t mk(input logic [3:0] bus, input logic [13:0] we, input logic [3:0] alu,
                              input logic [1:0] inc, input logic dm, input logic eop);
    out_t o;
    o          = '0;
    o.bus_ld   = bus;
    o.write_en = we;
    o.alu_mode = alu;
    o.inc      = inc;
    o.dm_wr    = dm;
    o.end_op   = eop;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Entered at posedge+1 of the cycle to verify; leaves at posedge+1 of the next cycle.
  task automatic cyc_check(input string name, input out_t exp);
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  out_t zero, f1, f2, f3, halt_o;

  typedef struct {
    logic [7:0] ir;
    logic       z;
    int         n;
    out_t       e0;
    out_t       e1;
    out_t       e2;
  } vec_t;

  vec_t tbl[10];

  // Reference: execute length and outputs per opcode from the instruction list.
  function automatic int ex_len(input logic [7:0] op, input logic zz);
    if (op == 8'd1 || op == 8'd10) return 2;
    if (op == 8'd13) return 3;
    if (op == 8'd27) return zz ? 1 : 2;
    return 1;
  endfunction

  function automatic out_t ex_out(input logic [7:0] op, input logic zz, input int k);
    out_t o;
    o = '0;
    if (op == 8'd1)       o = mk(4'd8, (k == 1) ? 14'h0010 : 14'h0, 4'd0, 2'b00, 1'b0, 1'b0);
    else if (op == 8'd2)  o = mk(4'd5, 14'h0001, 4'd0, 2'b00, 1'b0, 1'b0);
    else if (op == 8'd10) o = mk(4'd4, (k == 1) ? 14'h0010 : 14'h0, (k == 1) ? 4'd1 : 4'd0, 2'b00, 1'b0, 1'b0);
    else if (op == 8'd13) begin
      if (k == 0)      o = mk(4'd3, 14'h0008, 4'd0, 2'b00, 1'b0, 1'b0);
      else if (k == 1) o = mk(4'd0, 14'h0, 4'd0, 2'b00, 1'b1, 1'b0);
      else             o = mk(4'd0, 14'h0, 4'd0, 2'b10, 1'b0, 1'b0);
    end
    else if (op == 8'd15) o = mk(4'd4, 14'h0010, 4'd3, 2'b00, 1'b0, 1'b0);
    else if (op == 8'd27) begin
      if (zz)          o = mk(4'd0, 14'h0, 4'd0, 2'b01, 1'b0, 1'b0);
      else if (k == 0) o = mk(4'd1, 14'h0001, 4'd0, 2'b00, 1'b0, 1'b0);
      else             o = mk(4'd9, 14'h0002, 4'd0, 2'b00, 1'b0, 1'b0);
    end
    return o;
  endfunction

  task automatic do_fetch(input string tag);
    cyc_check({tag, "_f1"}, f1);
    cyc_check({tag, "_f2"}, f2);
    cyc_check({tag, "_f3"}, f3);
  endtask

  initial begin
    logic [7:0] op;
    logic       zsel;
    int         len;

    zero   = '0;
    f1     = mk(4'd1, 14'h0001, 4'd0, 2'b00, 1'b0, 1'b0);
    f2     = mk(4'd0, 14'h0000, 4'd0, 2'b01, 1'b0, 1'b0);
    f3     = mk(4'd9, 14'h0004, 4'd0, 2'b00, 1'b0, 1'b0);
    halt_o = mk(4'd0, 14'h0000, 4'd0, 2'b00, 1'b0, 1'b1);

    tbl[0] = '{8'd1,   1'b0, 2, mk(4'd8, 14'h0, 4'd0, 2'b00, 1'b0, 1'b0), mk(4'd8, 14'h0010, 4'd0, 2'b00, 1'b0, 1'b0), zero};
    tbl[1] = '{8'd2,   1'b0, 1, mk(4'd5, 14'h0001, 4'd0, 2'b00, 1'b0, 1'b0), zero, zero};
    tbl[2] = '{8'd10,  1'b1, 2, mk(4'd4, 14'h0, 4'd0, 2'b00, 1'b0, 1'b0), mk(4'd4, 14'h0010, 4'd1, 2'b00, 1'b0, 1'b0), zero};
    tbl[3] = '{8'd15,  1'b0, 1, mk(4'd4, 14'h0010, 4'd3, 2'b00, 1'b0, 1'b0), zero, zero};
    tbl[4] = '{8'd13,  1'b0, 3, mk(4'd3, 14'h0008, 4'd0, 2'b00, 1'b0, 1'b0), mk(4'd0, 14'h0, 4'd0, 2'b00, 1'b1, 1'b0),
               mk(4'd0, 14'h0, 4'd0, 2'b10, 1'b0, 1'b0)};
    tbl[5] = '{8'd27,  1'b0, 2, mk(4'd1, 14'h0001, 4'd0, 2'b00, 1'b0, 1'b0), mk(4'd9, 14'h0002, 4'd0, 2'b00, 1'b0, 1'b0), zero};
    tbl[6] = '{8'd27,  1'b1, 1, mk(4'd0, 14'h0, 4'd0, 2'b01, 1'b0, 1'b0), zero, zero};
    tbl[7] = '{8'h00,  1'b0, 1, zero, zero, zero};
    tbl[8] = '{8'hFF,  1'b1, 1, zero, zero, zero};
    tbl[9] = '{8'd3,   1'b0, 1, zero, zero, zero};

    // Reset: outputs zero while held, and for the half cycle after release.
    rst   = 1'b1;
    cu.ir = 8'd0;
    cu.z  = 1'b0;
    #1;
    check("reset_async", zero);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", zero);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc_check("post_release_idle", zero);

    // Opcode table; the next iteration's FETCH1 also confirms return to fetch.
    for (int i = 0; i < 10; i++) begin
      cu.ir = tbl[i].ir;
      cu.z  = tbl[i].z;
      do_fetch($sformatf("vec%0d", i));
      cyc_check($sformatf("vec%0d_ex1", i), tbl[i].e0);
      if (tbl[i].n > 1) cyc_check($sformatf("vec%0d_ex2", i), tbl[i].e1);
      if (tbl[i].n > 2) cyc_check($sformatf("vec%0d_ex3", i), tbl[i].e2);
    end

    // JPNZ path chosen in EX1 must survive z rising during EX2.
    cu.ir = 8'd27;
    cu.z  = 1'b0;
    do_fetch("jpnz_flip");
    cyc_check("jpnz_flip_ex1", mk(4'd1, 14'h0001, 4'd0, 2'b00, 1'b0, 1'b0));
    cu.z = 1'b1;
    cyc_check("jpnz_flip_ex2", mk(4'd9, 14'h0002, 4'd0, 2'b00, 1'b0, 1'b0));

    // Randomized instruction stream with z toggling outside EX1.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: op = 8'd1;
        1: op = 8'd2;
        2: op = 8'd10;
        3: op = 8'd13;
        4: op = 8'd15;
        5, 6: op = 8'd27;
        default: begin
          op = 8'($urandom_range(0, 255));
          while (op == 8'd1 || op == 8'd2 || op == 8'd10 || op == 8'd13 ||
                 op == 8'd15 || op == 8'd27 || op == 8'd28)
            op = 8'($urandom_range(0, 255));
        end
      endcase
      zsel  = 1'($urandom_range(0, 1));
      len   = ex_len(op, zsel);
      cu.ir = op;
      for (int c = 0; c < 3 + len; c++) begin
        cu.z = (c == 3) ? zsel : 1'($urandom_range(0, 1));
        if (c == 0)      cyc_check($sformatf("rnd%0d_op%0d_f1", n, op), f1);
        else if (c == 1) cyc_check($sformatf("rnd%0d_op%0d_f2", n, op), f2);
        else if (c == 2) cyc_check($sformatf("rnd%0d_op%0d_f3", n, op), f3);
        else             cyc_check($sformatf("rnd%0d_op%0d_ex%0d", n, op, c - 2), ex_out(op, zsel, c - 3));
      end
    end

    // Reset in the middle of STACI EX2 aborts at once and fetch restarts.
    cu.ir = 8'd13;
    cu.z  = 1'b0;
    do_fetch("abort");
    cyc_check("abort_ex1", mk(4'd3, 14'h0008, 4'd0, 2'b00, 1'b0, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    check("abort_async_zero", zero);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc_check("abort_release_idle", zero);
    do_fetch("abort_restart");
    cyc_check("abort_restart_ex1", mk(4'd3, 14'h0008, 4'd0, 2'b00, 1'b0, 1'b0));
    cyc_check("abort_restart_ex2", mk(4'd0, 14'h0, 4'd0, 2'b00, 1'b1, 1'b0));
    cyc_check("abort_restart_ex3", mk(4'd0, 14'h0, 4'd0, 2'b10, 1'b0, 1'b0));

    // ENDOP then HALT held; reset clears end_op immediately.
    cu.ir = 8'd28;
    do_fetch("endop");
    cyc_check("endop_ex1", halt_o);
    for (int h = 0; h < 7; h++) begin
      cu.ir = 8'($urandom_range(0, 255));
      cu.z  = 1'($urandom_range(0, 1));
      cyc_check($sformatf("halt_hold%0d", h), halt_o);
    end
    #2;
    rst = 1'b1;
    #1;
    check("halt_rst_zero", zero);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    cu.ir = 8'd2;
    cyc_check("halt_release_idle", zero);
    do_fetch("after_halt");
    cyc_check("after_halt_ex1", mk(4'd5, 14'h0001, 4'd0, 2'b00, 1'b0, 1'b0));
    cyc_check("after_halt_next_f1", f1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
